// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester and 4-bit adder bundle for the nibble-serial add controller.
// slave: controller side; master: requester plus external adder side.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  modport slave (
    input  start, op_sub, op_a, op_b,
    input  add_sum, add_cout,
    output busy, done, result, carry, ovf,
    output add_a, add_b, add_cin
  );

  modport master (
    output start, op_sub, op_a, op_b,
    output add_sum, add_cout,
    input  busy, done, result, carry, ovf,
    input  add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Serial W-bit add/sub over a shared 4-bit adder, LSB nibble first.
// Ports: clk, rst_n (async low), bus (slave: start/op/result + adder).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  result;
  logic [IW-1:0] idx;
  logic          carry_reg;
  logic          carry;
  logic          ovf;
  logic          run;
  logic          last;

  assign run  = (state == RUN);
  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    bus.add_a   = 4'd0;
    bus.add_b   = 4'd0;
    bus.add_cin = 1'b0;
    if (run) begin
      bus.add_a   = a_reg[4*idx +: 4];
      bus.add_b   = b_reg[4*idx +: 4];
      bus.add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.op_a;
            // subtract as A + ~B + 1
            b_reg     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.op_sub;
            idx       <= '0;
            result    <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[4*idx +: 4] <= bus.add_sum;
          carry_reg          <= bus.add_cout;
          if (last) begin
            carry <= bus.add_cout;
            ovf   <= (a_reg[W-1] == b_reg[W-1]) &&
                     (bus.add_sum[3] != a_reg[W-1]);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = run;
  assign bus.done   = (state == DONE);
  assign bus.result = result;
  assign bus.carry  = carry;
  assign bus.ovf    = ovf;
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencing controller that performs NIBBLES*4-bit add/subtract using one external 4-bit ripple adder (a/b/car_in -> sum/car_out), one nibble per cycle, LSB nibble first.
- Holds the inter-nibble carry in a flop, assembles the wide result, and reports carry/borrow and signed overflow.
- Sits between a requesting unit (start/done handshake) and the shared 4-bit adder datapath.

Parameters:
- NIBBLES, 4, number of nibbles per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- result  output  W  sum/difference; valid from done until next accepted start.
- carry  output  1  final adder carry-out (for subtract: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow of the W-bit operation.
- add_a  output  4  to adder a.
- add_b  output  4  to adder b.
- add_cin  output  1  to adder car_in.
- add_sum  input  4  from adder sum (combinational path, same cycle).
- add_cout  input  1  from adder car_out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, carry=0, ovf=0, internal a_reg/b_reg/idx/carry_reg=0; add_a/add_b/add_cin=0. Reset asserted mid-RUN aborts immediately and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, latch a_reg=op_a, b_reg=(op_sub ? ~op_b : op_b), carry_reg=op_sub, idx=0, clear result; go RUN. start=0 stays IDLE.
- RUN: drive add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry_reg (combinational from registers). Each edge: result[4*idx+:4]<=add_sum, carry_reg<=add_cout, idx<=idx+1. On the edge where idx=NIBBLES-1, also set carry<=add_cout and ovf<=(a_msb==b_msb)&&(add_sum[3]!=a_msb), using a_reg/b_reg bit W-1 (b after inversion); go DONE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally. start is ignored in RUN and DONE (no queuing, no restart).
- Outside RUN, add_a/add_b/add_cin are driven to 0.
- Latency: start accepted at edge k; busy=1 for cycles k+1..k+NIBBLES; done=1 in cycle k+NIBBLES+1. Back-to-back: earliest next accept is the edge ending the first IDLE cycle after DONE, so throughput is one op per NIBBLES+2 cycles.
- result, carry and ovf hold their values through IDLE until the next accepted start (result cleared at accept; carry/ovf updated only at the final nibble).
- idx width = clog2(NIBBLES); the counter never wraps past NIBBLES-1.
- Arithmetic is modulo 2^W; carry and ovf are reported separately. For subtract, carry=0 means borrow (A<B unsigned).

Test Plan (NIBBLES=4):
- Reset: drive rst_n=0 with random inputs -> all outputs 0; release -> IDLE, busy=0.
- Add 0x1234+0x0FFF, op_sub=0 -> busy for 4 cycles, done next cycle; result=0x2233, carry=0, ovf=0; add_cin sequence 0,1,1,1 (nibbles 0..2 carry out).
- Full-width carry propagate 0xFFFF+0x0001 -> result=0x0000, carry=1, ovf=0; 0x7FFF+0x0001 -> result=0x8000, carry=0, ovf=1.
- Subtract 0x0005-0x0007, op_sub=1 -> result=0xFFFE, carry=0 (borrow), ovf=0; 0x8000-0x0001 -> result=0x7FFF, carry=1, ovf=1.
- Start held high and pulsed during RUN/DONE with different operands -> ignored: exactly one done per accepted start, result matches the first operands, next accept only from IDLE.
- rst_n pulsed low at RUN cycle 2 -> immediate IDLE, no done; outputs 0; a subsequent 0x0001+0x0001 gives result=0x0002.
